pcie_read_tag_scheduler: RTL



---
 rtl/pcie_dma_pkg.sv | 13 +
 rtl/pcie_tag_beat_tracker.sv | 49 ++++
 rtl/pcie_read_tag_scheduler.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pcie_dma_pkg.sv
// Shared sizing for the DMA read path: tag-ring geometry, beats per request
// and the 128-byte request slot that outbound reads are aligned to.
package pcie_dma_pkg;

   localparam int TAG_BITS        = 5;
   localparam int MAX_OUTSTANDING = 32;
   localparam int BEATS           = 16;
   localparam int REQ_BYTES       = 128;
   localparam int REQ_OFFSET_BITS = $clog2(REQ_BYTES);

   typedef logic [TAG_BITS-1:0] tag_t;

endpackage

// File: rtl/pcie_tag_beat_tracker.sv
// Per-tag completion beat counters and done bits for the read tag ring.
// A tag is cleared on allocation, counts beats until BEATS, and its done bit drops on retirement.
module pcie_tag_beat_tracker #(
   parameter int TAG_BITS = pcie_dma_pkg::TAG_BITS,
   parameter int BEATS    = pcie_dma_pkg::BEATS
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                clear_valid,
   input  logic [TAG_BITS-1:0] clear_tag,
   input  logic                inc_valid,
   input  logic [TAG_BITS-1:0] inc_tag,
   output logic                inc_done,
   input  logic [TAG_BITS-1:0] query_tag,
   output logic                query_done,
   input  logic                retire_clear
);
   import pcie_dma_pkg::*;

   localparam int NUM_TAGS = 1 << TAG_BITS;
   localparam int CW       = $clog2(BEATS + 1);

   logic [CW-1:0]       beat_count [NUM_TAGS];
   logic [NUM_TAGS-1:0] done;

   // Allocation wins over everything; the last beat sets done in the same update.
   always_ff @(posedge clock) begin
      if (reset) begin
         done <= '0;
         for (int i = 0; i < NUM_TAGS; i++) beat_count[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_TAGS; i++) begin
            if (clear_valid && clear_tag == TAG_BITS'(i)) begin
               beat_count[i] <= '0;
               done[i]       <= 1'b0;
            end else if (retire_clear && query_tag == TAG_BITS'(i)) begin
               done[i] <= 1'b0;
            end else if (inc_valid && inc_tag == TAG_BITS'(i)) begin
               beat_count[i] <= beat_count[i] + 1'b1;
               if (beat_count[i] == CW'(BEATS - 1)) done[i] <= 1'b1;
            end
         end
      end
   end

   assign query_done = done[query_tag];
   assign inc_done   = done[inc_tag];

endmodule

// File: rtl/pcie_read_tag_scheduler.sv
// Allocates PCIe read tags from a ring, issues read TLPs, and retires tags in order
// once all completion beats land. Optional watchdog enabled by PCIE_TAG_TIMEOUT_EN.
module pcie_read_tag_scheduler #(
   parameter int TAG_BITS        = pcie_dma_pkg::TAG_BITS,
   parameter int MAX_OUTSTANDING = pcie_dma_pkg::MAX_OUTSTANDING,
   parameter int BEATS           = pcie_dma_pkg::BEATS,
   parameter int TIMEOUT_CYCLES  = 4096
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [63:0]         req_addr,
   output logic                tx_valid,
   input  logic                tx_ready,
   output logic [63:0]         tx_addr,
   output logic [7:0]          tx_tag,
   input  logic                completion_valid,
   input  logic [7:0]          completion_tag,
   output logic                retire_valid,
   input  logic                retire_ready,
   output logic [7:0]          retire_tag,
   output logic [TAG_BITS:0]   outstanding,
   output logic                tag_error,
   output logic                timeout
);
   import pcie_dma_pkg::*;

   logic [TAG_BITS-1:0] head;
   logic [TAG_BITS-1:0] tail;
   logic [TAG_BITS-1:0] comp_tag_low;
   logic [TAG_BITS-1:0] comp_offset;
   logic                accept;
   logic                retire_fire;
   logic                in_flight;
   logic                inc_valid;
   logic                inc_done;
   logic                tail_done;
   logic                unused_addr_offset;

   assign req_ready   = (!tx_valid || tx_ready) &&
                        (outstanding < (TAG_BITS + 1)'(MAX_OUTSTANDING));
   assign accept      = req_valid && req_ready;
   assign retire_fire = retire_valid && retire_ready;

   // A tag is live when its distance from the oldest tag is below the live count.
   assign comp_tag_low = completion_tag[TAG_BITS-1:0];
   assign comp_offset  = comp_tag_low - tail;
   assign in_flight    = ((completion_tag >> TAG_BITS) == 8'd0) &&
                         ({1'b0, comp_offset} < outstanding);
   assign inc_valid    = completion_valid && in_flight && !inc_done;

   assign unused_addr_offset = ^req_addr[REQ_OFFSET_BITS-1:0];

   pcie_tag_beat_tracker #(
      .TAG_BITS (TAG_BITS),
      .BEATS    (BEATS)
   ) u_tracker (
      .clock        (clock),
      .reset        (reset),
      .clear_valid  (accept),
      .clear_tag    (head),
      .inc_valid    (inc_valid),
      .inc_tag      (comp_tag_low),
      .inc_done     (inc_done),
      .query_tag    (tail),
      .query_done   (tail_done),
      .retire_clear (retire_fire)
   );

   // retire_valid drops for a cycle after each retirement so the new tail is re-evaluated.
   always_ff @(posedge clock) begin
      if (reset) begin
         head         <= '0;
         tail         <= '0;
         outstanding  <= '0;
         tx_valid     <= 1'b0;
         tx_addr      <= '0;
         tx_tag       <= '0;
         retire_valid <= 1'b0;
         retire_tag   <= '0;
         tag_error    <= 1'b0;
      end else begin
         if (accept) begin
            tx_valid <= 1'b1;
            tx_addr  <= {req_addr[63:REQ_OFFSET_BITS], {REQ_OFFSET_BITS{1'b0}}};
            tx_tag   <= 8'(head);
            head     <= head + 1'b1;
         end else if (tx_ready) begin
            tx_valid <= 1'b0;
         end
         if (retire_fire) tail <= tail + 1'b1;
         case ({accept, retire_fire})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
         retire_valid <= retire_fire ? 1'b0 : (tail_done && outstanding != '0);
         retire_tag   <= 8'(tail);
         if (completion_valid && (!in_flight || inc_done)) tag_error <= 1'b1;
      end
   end

`ifdef PCIE_TAG_TIMEOUT_EN
   localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
   logic [WDW-1:0] watchdog;

   // Counts only while the oldest tag is still waiting on beats.
   always_ff @(posedge clock) begin
      if (reset) begin
         watchdog <= '0;
         timeout  <= 1'b0;
      end else if (retire_fire || outstanding == '0) begin
         watchdog <= '0;
      end else if (!tail_done) begin
         if (watchdog != WDW'(TIMEOUT_CYCLES)) watchdog <= watchdog + 1'b1;
         if (watchdog == WDW'(TIMEOUT_CYCLES - 1)) timeout <= 1'b1;
      end
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout = 1'b0;
`endif

endmodule
